// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: sample width used by the whole filter
// chain, the default I2S slot width, and the serial-data source select.
package audio_pkg;

  // Width of every processed audio sample (two's complement, MSB first).
  localparam int AUDIO_SAMPLE_WIDTH = 24;

  // Default number of bit-clock periods in one I2S channel slot.
  localparam int I2S_DEFAULT_SLOT_WIDTH = 32;

  // Source of the serial data bit for a given bit position in the frame.
  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2
  } sdata_sel_e;

endpackage : audio_pkg

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator for the I2S transmitter. Divides the system clock into
// the bit clock, flags the cycle whose ending edge drops the bit clock, and
// keeps the bit position within the stereo frame.
module i2s_clk_gen #(
  parameter int BCLK_DIV   = 2,
  parameter int SLOT_WIDTH = 32,
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1,
  localparam int BW = $clog2(2 * SLOT_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bclk,
  output logic          fall_stb,
  output logic [BW-1:0] b
);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_WIDTH - 1);

  logic [DW-1:0] r_div;
  logic          r_bclk;
  logic [BW-1:0] r_b;
  logic          w_wrap;

  // The divider wraps once per bit-clock half period; a wrap while bclk is
  // high is the falling edge. fall_stb is high in the cycle whose closing
  // clk edge performs that 1->0 transition, so downstream registers that
  // qualify on it update in the same edge as the bit clock falls.
  assign w_wrap   = (r_div == DIV_LAST);
  assign fall_stb = w_wrap & r_bclk;
  assign bclk     = r_bclk;
  assign b        = r_b;

  // Divider, bit clock and frame bit counter. The bit counter resets to the
  // last position so the first falling edge lands on frame start (b = 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_b    <= B_LAST;
    end else begin
      if (w_wrap) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (fall_stb) begin
        r_b <= (r_b == B_LAST) ? '0 : r_b + 1'b1;
      end
    end
  end

endmodule : i2s_clk_gen

// File: rtl/i2s_transmitter.sv
// I2S (Philips format) transmitter: accepts one stereo sample pair per frame,
// holds it in a one-deep buffer, and serializes it MSB first with the
// standard one-bit delay after each word-select change.
//
// Handshake: a pair transfers on a clk edge where s_valid && s_ready. s_ready
// is high exactly when the holding buffer is empty. While s_ready is low the
// inputs are ignored and the source must keep its pair stable. A transfer in
// the same edge as a frame start never reaches that frame; it waits in the
// buffer for the next one.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int BCLK_DIV     = 2,
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_DEFAULT_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    underrun
);

  localparam int BW = $clog2(2 * SLOT_WIDTH);

  // Bit positions (after the falling edge) that carry sample bits.
  localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SLOT_B  = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] L_FIRST = BW'(1);
  localparam logic [BW-1:0] L_LAST  = BW'(SAMPLE_WIDTH);
  localparam logic [BW-1:0] R_FIRST = BW'(SLOT_WIDTH + 1);
  localparam logic [BW-1:0] R_LAST  = BW'(SLOT_WIDTH + SAMPLE_WIDTH);

  // Clock generator outputs.
  logic          w_bclk;
  logic          w_fall;
  logic [BW-1:0] w_b;

  // Derived per-cycle controls.
  logic [BW-1:0] w_b_next;
  logic          w_frame_start;
  logic          w_xfer;
  sdata_sel_e    w_sel;

  // Holding buffer.
  logic                    r_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;

  // Shift registers and registered serial outputs.
  logic [SAMPLE_WIDTH-1:0] r_sh_l;
  logic [SAMPLE_WIDTH-1:0] r_sh_r;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_underrun;

  i2s_clk_gen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .bclk    (w_bclk),
    .fall_stb(w_fall),
    .b       (w_b)
  );

  // Word select and data follow the bit position that becomes current at the
  // falling edge, so everything is decoded from the counter's next value.
  assign w_b_next      = (w_b == B_LAST) ? '0 : w_b + 1'b1;
  assign w_frame_start = w_fall & (w_b == B_LAST);
  assign w_xfer        = s_valid & ~r_full;

  assign s_ready   = ~r_full;
  assign i2s_bclk  = w_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign underrun  = r_underrun;

  // Pick which channel (if any) supplies the bit at the upcoming position.
  always_comb begin
    w_sel = SEL_ZERO;
    if ((w_b_next >= L_FIRST) && (w_b_next <= L_LAST)) begin
      w_sel = SEL_LEFT;
    end else if ((w_b_next >= R_FIRST) && (w_b_next <= R_LAST)) begin
      w_sel = SEL_RIGHT;
    end
  end

  // One-deep holding buffer: drained by the frame-start load, refilled by the
  // handshake. A full buffer blocks the handshake, so both never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (w_frame_start && r_full) begin
      r_full <= 1'b0;
    end else if (w_xfer) begin
      r_full   <= 1'b1;
      r_hold_l <= s_left;
      r_hold_r <= s_right;
    end
  end

  // Serializer: load at frame start (zeros when the buffer is empty), then
  // shift each channel out MSB first during its data window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_l  <= '0;
      r_sh_r  <= '0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_fall) begin
      r_lrclk <= (w_b_next >= SLOT_B);
      if (w_frame_start) begin
        r_sdata <= 1'b0;
        r_sh_l  <= r_full ? r_hold_l : '0;
        r_sh_r  <= r_full ? r_hold_r : '0;
      end else begin
        case (w_sel)
          SEL_LEFT: begin
            r_sdata <= r_sh_l[SAMPLE_WIDTH-1];
            r_sh_l  <= {r_sh_l[SAMPLE_WIDTH-2:0], 1'b0};
          end
          SEL_RIGHT: begin
            r_sdata <= r_sh_r[SAMPLE_WIDTH-1];
            r_sh_r  <= {r_sh_r[SAMPLE_WIDTH-2:0], 1'b0};
          end
          default: begin
            r_sdata <= 1'b0;
          end
        endcase
      end
    end
  end

  // Underrun flag: single-cycle pulse when a frame starts with nothing buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start & ~r_full;
    end
  end

endmodule : i2s_transmitter

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: random stereo pairs are pushed through the
// handshake; a frame-level model predicts which pair each frame carries and
// when underruns occur, and a bit-level decoder reassembles the I2S stream.
module tb_i2s_transmitter;

  localparam int BD = 2;
  localparam int SW = 24;
  localparam int SL = 32;
  localparam int FL = 2 * SL * 2 * BD;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          underrun;

  always #5 clk = ~clk;

  i2s_transmitter #(
    .BCLK_DIV    (BD),
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .i2s_bclk (i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun (underrun)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Model time m_c counts clk edges since the last reset edge. Frames start
  // every FL edges from edge 2*BD; rising bclk edges fall at BD + k*2*BD.
  bit              m_valid = 1'b0;
  int              m_c = 0;
  bit              m_fs = 1'b0;
  bit              m_hold_v = 1'b0;
  logic [2*SW-1:0] m_hold = '0;
  bit              m_ur = 1'b0;
  bit              m_rdy;
  logic [2*SW-1:0] exp_q[$];
  int              cyc_err = 0;
  int              fmt_err = 0;
  int              frames_checked = 0;
  int              obs_ur = 0;
  int              exp_ur = 0;
  int              d_m;
  int              d_bp;
  logic [SW-1:0]   dec_l = '0;
  logic [SW-1:0]   dec_r = '0;

  always @(negedge clk) begin
    // Compare outputs with the state predicted for the last edge.
    if (m_valid) begin
      if (s_ready !== !m_hold_v) cyc_err++;
      if (underrun !== m_ur) cyc_err++;
      if (i2s_bclk !== (((m_c / BD) % 2) == 1)) cyc_err++;
      if (underrun === 1'b1) obs_ur++;
      // Receiver view: sample on every rising bclk inside a frame.
      if (m_c >= 3 * BD && ((m_c - BD) % (2 * BD)) == 0) begin
        d_m  = (m_c - BD) / (2 * BD);
        d_bp = (d_m - 1) % (2 * SL);
        if (i2s_lrclk !== (d_bp >= SL)) fmt_err++;
        if (d_bp >= 1 && d_bp <= SW) dec_l = {dec_l[SW-2:0], i2s_sdata};
        else if (d_bp >= SL + 1 && d_bp <= SL + SW) dec_r = {dec_r[SW-2:0], i2s_sdata};
        else if (i2s_sdata !== 1'b0) fmt_err++;
        if (d_bp == 2 * SL - 1) begin
          check_val("frame_expected_present", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
          if (exp_q.size() != 0) check_val("frame_data", {dec_l, dec_r}, exp_q.pop_front());
          check_val("frame_format", fmt_err, 0);
          check_val("frame_cycle_outputs", cyc_err, 0);
          fmt_err = 0;
          cyc_err = 0;
          frames_checked++;
        end
      end
    end
    // Advance the model across the coming edge using the current inputs.
    m_fs = 1'b0;
    if (rst) begin
      m_valid  = 1'b1;
      m_c      = 0;
      m_hold_v = 1'b0;
      m_ur     = 1'b0;
      exp_q.delete();
      fmt_err  = 0;
      dec_l    = '0;
      dec_r    = '0;
    end else if (m_valid) begin
      m_rdy = !m_hold_v;
      m_c++;
      m_ur = 1'b0;
      if (m_c >= 2 * BD && ((m_c - 2 * BD) % FL) == 0) begin
        m_fs = 1'b1;
        if (m_hold_v) begin
          exp_q.push_back(m_hold);
          m_hold_v = 1'b0;
        end else begin
          exp_q.push_back('0);
          m_ur = 1'b1;
          exp_ur++;
        end
      end
      if (s_valid && m_rdy) begin
        m_hold   = {s_left, s_right};
        m_hold_v = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    bit acc;
    int w;
    acc = 1'b0;
    w = 0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    while (!acc && w < 2 * FL) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      w++;
    end
    check_val("push_accepted", acc, 1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int n;
  int ur0;
  int c0;
  bit prev_bclk;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_bclk", i2s_bclk, 0);
    check_val("rst_lrclk", i2s_lrclk, 0);
    check_val("rst_sdata", i2s_sdata, 0);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_s_ready", s_ready, 1);

    // Release reset and push the known pair before the first frame start.
    rst = 1'b0;
    s_valid = 1'b1;
    s_left  = 24'h800001;
    s_right = 24'h7FFFFE;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_val("ready_after_first_push", s_ready, 0);
    n = 1;
    prev_bclk = i2s_bclk;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (prev_bclk && !i2s_bclk) break;
      prev_bclk = i2s_bclk;
    end
    check_val("first_fall_clk", n, 2 * BD);
    check_val("ready_after_load", s_ready, 1);

    // Streaming: eight random pairs, valid held across pairs.
    ur0 = obs_ur;
    for (int i = 0; i < 8; i++) begin
      push(SW'($urandom), SW'($urandom));
    end
    check_val("stream_no_underrun", obs_ur - ur0, 0);

    // Underrun: stay idle for two frames; exactly one empty frame start.
    ur0 = obs_ur;
    idle(2 * FL);
    check_val("idle_underrun_pulses", obs_ur - ur0, 1);
    push(SW'($urandom), SW'($urandom));
    idle(FL);

    // Backpressure: valid held high, data changing every clk.
    s_valid = 1'b1;
    for (int i = 0; i < 3 * FL; i++) begin
      s_left  = SW'($urandom);
      s_right = SW'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;

    // Mid-frame reset at b=10 with a pair sitting in the buffer.
    n = 0;
    while (!m_fs && n < 2 * FL) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("frame_start_found", m_fs, 1);
    c0 = m_c;
    push(SW'($urandom_range(1, 24'hFFFFFF)), SW'($urandom_range(1, 24'hFFFFFF)));
    n = 0;
    while (m_c < c0 + 10 * 2 * BD + 1 && n < 2 * FL) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("ready_before_mid_reset", s_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_bclk", i2s_bclk, 0);
    check_val("mid_rst_lrclk", i2s_lrclk, 0);
    check_val("mid_rst_sdata", i2s_sdata, 0);
    check_val("mid_rst_underrun", underrun, 0);
    check_val("mid_rst_s_ready", s_ready, 1);
    rst = 1'b0;
    idle(2 * FL);

    // Normal operation after the reset.
    push(SW'($urandom), SW'($urandom));
    idle(2 * FL);

    check_val("frames_checked_min", frames_checked > 15, 1);
    check_val("underrun_total", obs_ur, exp_ur);
    check_val("tail_cycle_outputs", cyc_err, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound the run in case the stream stops advancing.
  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_i2s_transmitter
